// File: rtl/xor_result_packer.sv
// xor_result_packer: collects the XOR stage's 1-bit result stream LSB-first
// into WIDTH-bit words, queues them in a DEPTH-entry FIFO and offers them on
// a valid/ready output port.
// Optional feature macro: XOR_RESULT_PACKER_PARITY_EN adds o_parity, the
// XOR-reduction of each word, computed at push time and stored with the word.
module xor_result_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         y_data,
  input  logic                         y_en,
  output logic                         y_rdy,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_en,
  input  logic                         o_rdy,
`ifdef XOR_RESULT_PACKER_PARITY_EN
  output logic                         o_parity,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] push_word;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             last_bit;
  logic             accept;
  logic             push;
  logic             pop;

  // Occupancy flags come straight from the registered word count, so y_rdy
  // depends only on state (and reset), never on o_rdy or y_en.
  always_comb begin
    full     = (word_count == CW'(DEPTH));
    empty    = (word_count == '0);
    last_bit = (bit_cnt == CNT_W'(WIDTH-1));
    y_rdy    = !RST && !(full && last_bit);
    accept   = y_en && y_rdy;
    push     = accept && last_bit;
    o_en     = !empty;
    pop      = o_en && o_rdy;
  end

  // The word being assembled with the incoming bit merged in; on the last
  // bit this is the complete word written to the FIFO on the same edge.
  always_comb begin
    push_word          = shift_reg;
    push_word[bit_cnt] = y_data;
  end

  // Deserialiser: bit counter and shift register, cleared after each push
  // so a new word never carries stale bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      if (last_bit) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else begin
        bit_cnt   <= bit_cnt + CNT_W'(1);
        shift_reg <= push_word;
      end
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Word count tracks occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   word_count <= word_count + CW'(1);
        2'b01:   word_count <= word_count - CW'(1);
        default: word_count <= word_count;
      endcase
    end
  end

  // Storage array holds no reset; its contents are only visible while o_en.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  assign o_data = empty ? '0 : mem[rd_ptr];

`ifdef XOR_RESULT_PACKER_PARITY_EN
  logic par_mem [DEPTH];

  // Parity is taken from the complete word at push time and stored with it.
  always_ff @(posedge CLK) begin
    if (push) par_mem[wr_ptr] <= ^push_word;
  end

  assign o_parity = empty ? 1'b0 : par_mem[rd_ptr];
`endif

  // A push into a full FIFO would lose a word; y_rdy must prevent it.
  no_push_when_full: assert property (@(posedge CLK) disable iff (RST) !(push && full));

endmodule

// File: tb/tb_xor_result_packer.sv
// tb_xor_result_packer: self-checking bench for xor_result_packer (8x4 main
// instance plus a 3x2 instance for the small-configuration boundary case).
// Honours XOR_RESULT_PACKER_PARITY_EN when defined.
module tb_xor_result_packer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       y_data, y_en, o_rdy;
  logic       y_rdy, o_en;
  logic [7:0] o_data;
  logic [2:0] word_count;

  logic       s_y_data, s_y_en, s_o_rdy;
  logic       s_y_rdy, s_o_en;
  logic [2:0] s_o_data;
  logic [1:0] s_word_count;

`ifdef XOR_RESULT_PACKER_PARITY_EN
  logic o_parity, s_o_parity;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // reference model: queue of complete words plus the partial word
  logic [7:0] exp_q[$];
  logic [7:0] popped[$];
  logic [7:0] acc;
  int         mc;
  int         accept_cnt;

  always #5 CLK = ~CLK;

  xor_result_packer #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .y_data(y_data), .y_en(y_en), .y_rdy(y_rdy),
    .o_data(o_data), .o_en(o_en), .o_rdy(o_rdy),
`ifdef XOR_RESULT_PACKER_PARITY_EN
    .o_parity(o_parity),
`endif
    .word_count(word_count)
  );

  xor_result_packer #(.WIDTH(3), .DEPTH(2)) dut_small (
    .CLK(CLK), .RST(RST), .y_data(s_y_data), .y_en(s_y_en), .y_rdy(s_y_rdy),
    .o_data(s_o_data), .o_en(s_o_en), .o_rdy(s_o_rdy),
`ifdef XOR_RESULT_PACKER_PARITY_EN
    .o_parity(s_o_parity),
`endif
    .word_count(s_word_count)
  );

  task automatic model_reset();
    exp_q.delete();
    acc = 8'h00;
    mc  = 0;
  endtask

  // one clock of the main DUT; model decides acceptance and pops from its own state
  task automatic tick();
    bit m_rdy, do_acc, do_pop;
    m_rdy  = !(exp_q.size() == 4 && mc == 7);
    do_acc = y_en && m_rdy;
    do_pop = (exp_q.size() != 0) && o_rdy;
    @(posedge CLK);
    if (do_pop) popped.push_back(exp_q.pop_front());
    if (do_acc) begin
      accept_cnt++;
      acc[mc] = y_data;
      mc++;
      if (mc == 8) begin
        exp_q.push_back(acc);
        acc = 8'h00;
        mc  = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    vectors++; if (o_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_o_en got=%b want=0", o_en); end
    vectors++; if (o_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_o_data got=%h want=00", o_data); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_word_count got=%0d want=0", word_count); end
    vectors++; if (y_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_y_rdy got=%b want=0", y_rdy); end
    vectors++; if (s_y_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_small_y_rdy got=%b want=0", s_y_rdy); end
`ifdef XOR_RESULT_PACKER_PARITY_EN
    vectors++; if (o_parity !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_o_parity got=%b want=0", o_parity); end
`endif
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    #1;
    vectors++; if (y_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL release_y_rdy got=%b want=1", y_rdy); end
  endtask

  task automatic test_basic_word();
    logic [7:0] bits;
    bits = 8'h8D;
    o_rdy = 1'b1;
    y_en  = 1'b1;
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      y_data = bits[i];
      tick();
      if (i == 6) begin
        vectors++; if (o_en !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_early_o_en got=%b want=0", o_en); end
      end
    end
    vectors++; if (o_en !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_o_en got=%b want=1", o_en); end
    vectors++; if (o_data !== 8'h8D) begin miscompares++; $display("[TB] FAIL basic_o_data got=%h want=8d", o_data); end
    vectors++; if (word_count !== 3'd1) begin miscompares++; $display("[TB] FAIL basic_count1 got=%0d want=1", word_count); end
`ifdef XOR_RESULT_PACKER_PARITY_EN
    vectors++; if (o_parity !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_parity got=%b want=0", o_parity); end
`endif
    y_en = 1'b0;
    tick();
    vectors++; if (o_en !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_o_en_drop got=%b want=0", o_en); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("[TB] FAIL basic_count0 got=%0d want=0", word_count); end
  endtask

  task automatic test_full_backpressure();
    logic [7:0] word;
    logic [7:0] want [4];
    want = '{8'h02, 8'h03, 8'h04, 8'h05};
    o_rdy = 1'b0;
    y_en  = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      word = 8'(w);
      for (int i = 0; i < 8; i++) begin
        y_data = word[i];
        tick();
      end
    end
    vectors++; if (word_count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_count got=%0d want=4", word_count); end
    vectors++; if (o_data !== 8'h01) begin miscompares++; $display("[TB] FAIL full_head got=%h want=01", o_data); end
    word = 8'h05;
    for (int i = 0; i < 7; i++) begin
      y_data = word[i];
      tick();
    end
    vectors++; if (y_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_last_bit_y_rdy got=%b want=0", y_rdy); end
    y_data = word[7];
    repeat (2) tick();
    vectors++; if (y_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_hold_y_rdy got=%b want=0", y_rdy); end
    vectors++; if (word_count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_hold_count got=%0d want=4", word_count); end
    vectors++; if (o_data !== 8'h01) begin miscompares++; $display("[TB] FAIL full_hold_head got=%h want=01", o_data); end
    o_rdy = 1'b1;
    tick();
    vectors++; if (word_count !== 3'd3) begin miscompares++; $display("[TB] FAIL full_pop_count got=%0d want=3", word_count); end
    vectors++; if (y_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL full_pop_y_rdy got=%b want=1", y_rdy); end
    vectors++; if (o_data !== 8'h02) begin miscompares++; $display("[TB] FAIL full_pop_head got=%h want=02", o_data); end
    o_rdy = 1'b0;
    tick();
    vectors++; if (word_count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_refill_count got=%0d want=4", word_count); end
    y_en  = 1'b0;
    o_rdy = 1'b1;
    popped.delete();
    repeat (4) tick();
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("[TB] FAIL full_drain_count got=%0d want=0", word_count); end
    vectors++;
    if (popped.size() != 4) begin
      miscompares++; $display("[TB] FAIL full_drain_size got=%0d want=4", popped.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (popped[i] !== want[i]) begin
          miscompares++; $display("[TB] FAIL full_drain_word%0d got=%h want=%h", i, popped[i], want[i]);
        end
    end
  endtask

  task automatic test_stream();
    logic [7:0] sent [10];
    int max_wc;
    max_wc = 0;
    o_rdy = 1'b1;
    y_en  = 1'b1;
    popped.delete();
    for (int w = 0; w < 10; w++) begin
      sent[w] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        y_data = sent[w][i];
        tick();
        if (int'(word_count) > max_wc) max_wc = int'(word_count);
      end
    end
    y_en = 1'b0;
    repeat (2) tick();
    vectors++; if (max_wc > 1) begin miscompares++; $display("[TB] FAIL stream_max_count got=%0d want<=1", max_wc); end
    vectors++;
    if (popped.size() != 10) begin
      miscompares++; $display("[TB] FAIL stream_size got=%0d want=10", popped.size());
    end else begin
      for (int i = 0; i < 10; i++)
        if (popped[i] !== sent[i]) begin
          miscompares++; $display("[TB] FAIL stream_word%0d got=%h want=%h", i, popped[i], sent[i]);
        end
    end
  endtask

  task automatic test_async_reset();
    o_rdy = 1'b0;
    y_en  = 1'b1;
    for (int i = 0; i < 21; i++) begin
      y_data = 1'($urandom);
      tick();
    end
    vectors++; if (word_count !== 3'd2) begin miscompares++; $display("[TB] FAIL arst_pre_count got=%0d want=2", word_count); end
    #2;
    RST = 1'b1;
    #1;
    vectors++; if (o_en !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_o_en got=%b want=0", o_en); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("[TB] FAIL arst_count got=%0d want=0", word_count); end
    vectors++; if (y_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_y_rdy got=%b want=0", y_rdy); end
    y_en = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    #1;
    o_rdy  = 1'b1;
    y_en   = 1'b1;
    y_data = 1'b1;
    popped.delete();
    repeat (8) tick();
    vectors++; if (o_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL arst_fresh_word got=%h want=ff", o_data); end
    vectors++; if (word_count !== 3'd1) begin miscompares++; $display("[TB] FAIL arst_fresh_count got=%0d want=1", word_count); end
    y_en = 1'b0;
    tick();
    vectors++;
    if (popped.size() != 1 || popped[0] !== 8'hFF) begin
      miscompares++; $display("[TB] FAIL arst_only_one got_size=%0d want_size=1 want=ff", popped.size());
    end
  endtask

  task automatic test_random();
    bit         hold;
    logic [7:0] prev;
    int         cycles;
    bit         m_rdy;
    accept_cnt = 0;
    cycles = 0;
    while (accept_cnt < 1000 && cycles < 20000) begin
      y_en   = ($urandom_range(0, 3) != 0);
      y_data = 1'($urandom);
      o_rdy  = 1'($urandom);
      hold   = o_en && !o_rdy;
      prev   = o_data;
      tick();
      cycles++;
      m_rdy = !(exp_q.size() == 4 && mc == 7);
      vectors++; if (o_en !== (exp_q.size() != 0)) begin miscompares++; $display("[TB] FAIL rand_o_en cyc=%0d got=%b want=%b", cycles, o_en, exp_q.size() != 0); end
      vectors++; if (word_count !== 3'(exp_q.size())) begin miscompares++; $display("[TB] FAIL rand_count cyc=%0d got=%0d want=%0d", cycles, word_count, exp_q.size()); end
      vectors++; if (y_rdy !== m_rdy) begin miscompares++; $display("[TB] FAIL rand_y_rdy cyc=%0d got=%b want=%b", cycles, y_rdy, m_rdy); end
      vectors++; if (word_count > 3'd4) begin miscompares++; $display("[TB] FAIL rand_count_range cyc=%0d got=%0d want<=4", cycles, word_count); end
      if (exp_q.size() != 0) begin
        vectors++; if (o_data !== exp_q[0]) begin miscompares++; $display("[TB] FAIL rand_o_data cyc=%0d got=%h want=%h", cycles, o_data, exp_q[0]); end
`ifdef XOR_RESULT_PACKER_PARITY_EN
        vectors++; if (o_parity !== ^exp_q[0]) begin miscompares++; $display("[TB] FAIL rand_parity cyc=%0d got=%b want=%b", cycles, o_parity, ^exp_q[0]); end
`endif
      end
      if (hold) begin
        vectors++; if (o_data !== prev) begin miscompares++; $display("[TB] FAIL rand_stable cyc=%0d got=%h want=%h", cycles, o_data, prev); end
      end
    end
    vectors++; if (accept_cnt < 1000) begin miscompares++; $display("[TB] FAIL rand_timeout got=%0d want=1000 bits", accept_cnt); end
    y_en  = 1'b0;
    o_rdy = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_small_config();
    logic [8:0] sb;
    sb = 9'b001010111;
    s_o_rdy = 1'b0;
    s_y_en  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_y_data = sb[i];
      @(posedge CLK); #1;
    end
    vectors++; if (s_word_count !== 2'd2) begin miscompares++; $display("[TB] FAIL small_count got=%0d want=2", s_word_count); end
    vectors++; if (s_o_data !== 3'h7) begin miscompares++; $display("[TB] FAIL small_head got=%h want=7", s_o_data); end
    vectors++; if (s_y_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL small_y_rdy got=%b want=0", s_y_rdy); end
    s_y_data = sb[8];
    @(posedge CLK); #1;
    vectors++; if (s_y_rdy !== 1'b0 || s_word_count !== 2'd2) begin miscompares++; $display("[TB] FAIL small_stall got=%b/%0d want=0/2", s_y_rdy, s_word_count); end
    s_o_rdy = 1'b1;
    @(posedge CLK); #1;
    vectors++; if (s_o_data !== 3'h2) begin miscompares++; $display("[TB] FAIL small_pop_head got=%h want=2", s_o_data); end
    vectors++; if (s_y_rdy !== 1'b1 || s_word_count !== 2'd1) begin miscompares++; $display("[TB] FAIL small_pop got=%b/%0d want=1/1", s_y_rdy, s_word_count); end
`ifdef XOR_RESULT_PACKER_PARITY_EN
    vectors++; if (s_o_parity !== 1'b1) begin miscompares++; $display("[TB] FAIL small_parity got=%b want=1", s_o_parity); end
`endif
    s_o_rdy = 1'b0;
    @(posedge CLK); #1;
    vectors++; if (s_word_count !== 2'd2) begin miscompares++; $display("[TB] FAIL small_push_count got=%0d want=2", s_word_count); end
    s_y_en  = 1'b0;
    s_o_rdy = 1'b1;
    @(posedge CLK); #1;
    vectors++; if (s_o_data !== 3'h1) begin miscompares++; $display("[TB] FAIL small_third_word got=%h want=1", s_o_data); end
    @(posedge CLK); #1;
    vectors++; if (s_o_en !== 1'b0 || s_word_count !== 2'd0) begin miscompares++; $display("[TB] FAIL small_empty got=%b/%0d want=0/0", s_o_en, s_word_count); end
  endtask

  initial begin
    RST      = 1'b1;
    y_data   = 1'b0;
    y_en     = 1'b0;
    o_rdy    = 1'b0;
    s_y_data = 1'b0;
    s_y_en   = 1'b0;
    s_o_rdy  = 1'b0;
    accept_cnt = 0;
    model_reset();
    test_reset();
    test_basic_word();
    test_full_backpressure();
    test_stream();
    test_async_reset();
    test_random();
    test_small_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
